// File: rtl/dram_rdata_buffer.sv
// dram_rdata_buffer: R-beat decoupling FIFO between the AXI interconnect (master side, *_M)
// and the DRAM wrapper (*_S). An AR is forwarded only when the FIFO has room reserved for its
// whole burst, so the DRAM side is never stalled by RREADY backpressure.
// Optional feature macro: DRAM_RBUF_LASTCHK_EN (per-burst RLAST position checking, LAST_ERR).
module dram_rdata_buffer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AXI_IDS_BITS  = 8,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned AXI_LEN_BITS  = 4,
  parameter int unsigned AXI_SIZE_BITS = 3,
  parameter int unsigned AXI_DATA_BITS = 32,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // AR from interconnect
  input  logic [AXI_IDS_BITS-1:0]  ARID_M,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M,
  input  logic [1:0]               ARBURST_M,
  input  logic                     ARVALID_M,
  output logic                     ARREADY_M,
  // AR to DRAM wrapper
  output logic [AXI_IDS_BITS-1:0]  ARID_S,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]               ARBURST_S,
  output logic                     ARVALID_S,
  input  logic                     ARREADY_S,
  // R from DRAM wrapper
  input  logic [AXI_IDS_BITS-1:0]  RID_S,
  input  logic [AXI_DATA_BITS-1:0] RDATA_S,
  input  logic [1:0]               RRESP_S,
  input  logic                     RLAST_S,
  input  logic                     RVALID_S,
  output logic                     RREADY_S,
  // R to interconnect
  output logic [AXI_IDS_BITS-1:0]  RID_M,
  output logic [AXI_DATA_BITS-1:0] RDATA_M,
  output logic [1:0]               RRESP_M,
  output logic                     RLAST_M,
  output logic                     RVALID_M,
  input  logic                     RREADY_M,
  // status
  output logic [CNT_W-1:0]         COUNT,
  output logic                     LAST_ERR
);

  localparam int unsigned BEAT_W = AXI_IDS_BITS + AXI_DATA_BITS + 2 + 1;
  localparam int unsigned LEN1_W = CNT_W + 1;

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d, credits_q, credits_d;
  logic [LEN1_W-1:0] burst_len;
  logic              full, empty, push, pop, ar_hs, credit_ok, lq_ok;
  logic [BEAT_W-1:0] rd_beat;

  // AR passthrough; forwarded only when the whole burst has reserved space
  assign ARID_S    = ARID_M;
  assign ARADDR_S  = ARADDR_M;
  assign ARLEN_S   = ARLEN_M;
  assign ARSIZE_S  = ARSIZE_M;
  assign ARBURST_S = ARBURST_M;
  assign burst_len = LEN1_W'(ARLEN_M) + LEN1_W'(1);
  assign credit_ok = (LEN1_W'(credits_q) >= burst_len) & lq_ok;
  assign ARVALID_S = ARVALID_M & credit_ok;
  assign ARREADY_M = ARREADY_S & credit_ok;
  assign ar_hs     = ARVALID_S & ARREADY_S;

  // FIFO handshakes and show-ahead read port (zeros while empty, no bypass)
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign RREADY_S = ~full;
  assign RVALID_M = ~empty;
  assign push     = RVALID_S & ~full;
  assign pop      = ~empty & RREADY_M;
  assign rd_beat  = empty ? '0 : mem_q[rptr_q];
  assign {RID_M, RDATA_M, RRESP_M, RLAST_M} = rd_beat;
  assign COUNT    = count_q;

  // Next-state for pointers, occupancy and credits
  always_comb begin
    wptr_d    = wptr_q + PTR_W'(push);
    rptr_d    = rptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    credits_d = credits_q - (ar_hs ? CNT_W'(burst_len) : '0) + CNT_W'(pop);
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      credits_q <= CNT_W'(DEPTH);
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
    end
  end

  // Beat storage, not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {RID_S, RDATA_S, RRESP_S, RLAST_S};
  end

`ifdef DRAM_RBUF_LASTCHK_EN
  localparam int unsigned LQ_DEPTH = 4;
  localparam int unsigned LQ_PW    = 2;
  localparam int unsigned LQ_CW    = 3;

  logic [CNT_W-1:0] lq_mem_q [LQ_DEPTH];
  logic [LQ_PW-1:0] lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
  logic [LQ_CW-1:0] lq_cnt_q, lq_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_nxt, lq_head;
  logic             last_err_q, last_err_d, lq_pop, lq_empty;

  assign lq_ok    = (lq_cnt_q != LQ_CW'(LQ_DEPTH));
  assign lq_empty = (lq_cnt_q == '0);
  assign lq_head  = lq_mem_q[lq_rp_q];
  assign beat_nxt = beat_cnt_q + CNT_W'(1);
  assign LAST_ERR = last_err_q;

  // Track beats of the oldest burst and flag RLAST in the wrong position
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    last_err_d = last_err_q;
    lq_pop     = 1'b0;
    if (push) begin
      if (lq_empty) begin
        last_err_d = 1'b1;
      end else if (RLAST_S) begin
        if (beat_nxt != lq_head) last_err_d = 1'b1;
        lq_pop     = 1'b1;
        beat_cnt_d = '0;
      end else begin
        if (beat_nxt == lq_head) last_err_d = 1'b1;
        beat_cnt_d = beat_nxt;
      end
    end
    lq_wp_d  = lq_wp_q + LQ_PW'(ar_hs);
    lq_rp_d  = lq_rp_q + LQ_PW'(lq_pop);
    lq_cnt_d = lq_cnt_q + LQ_CW'(ar_hs) - LQ_CW'(lq_pop);
  end

  // Length-queue control and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      lq_wp_q    <= '0;
      lq_rp_q    <= '0;
      lq_cnt_q   <= '0;
      beat_cnt_q <= '0;
      last_err_q <= 1'b0;
    end else begin
      lq_wp_q    <= lq_wp_d;
      lq_rp_q    <= lq_rp_d;
      lq_cnt_q   <= lq_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  // Burst-length storage, not reset
  always_ff @(posedge clk) begin
    if (ar_hs) lq_mem_q[lq_wp_q] <= CNT_W'(burst_len);
  end
`else
  assign lq_ok    = 1'b1;
  assign LAST_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_rdata_buffer.sv
// Testbench for dram_rdata_buffer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_dram_rdata_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID_M, ARID_S, RID_S, RID_M;
  logic [31:0] ARADDR_M, ARADDR_S, RDATA_S, RDATA_M;
  logic [3:0]  ARLEN_M, ARLEN_S;
  logic [2:0]  ARSIZE_M, ARSIZE_S;
  logic [1:0]  ARBURST_M, ARBURST_S, RRESP_S, RRESP_M;
  logic        ARVALID_M, ARREADY_M, ARVALID_S, ARREADY_S;
  logic        RLAST_S, RVALID_S, RREADY_S, RLAST_M, RVALID_M, RREADY_M;
  logic [4:0]  COUNT;
  logic        LAST_ERR;

  dram_rdata_buffer dut (
    .clk(clk), .rst(rst),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .COUNT(COUNT), .LAST_ERR(LAST_ERR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int    vectors = 0;
  int    miscompares = 0;
  bit    en = 1'b0;

  // reference model state
  beat_t mq[$];
  int    m_credits = 16;
  bit    m_err = 1'b0;
  int    lq[$];
  int    m_bc = 0;

`ifdef DRAM_RBUF_LASTCHK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_credit_ok();
    bit ok;
    ok = (m_credits >= int'(ARLEN_M) + 1);
`ifdef DRAM_RBUF_LASTCHK_EN
    ok = ok && (lq.size() < 4);
`endif
    return ok;
  endfunction

  // Reference model: FIFO as a queue, credits as an integer, RLAST checker as a length list
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete(); lq.delete();
      m_credits = 16; m_err = 1'b0; m_bc = 0;
    end else begin
      int  sz;
      bit  do_pop, do_push, do_ar;
      beat_t b;
      sz      = mq.size();
      do_pop  = (sz != 0) && RREADY_M;
      do_push = (sz != 16) && RVALID_S;
      do_ar   = ARVALID_M && ARREADY_S && model_credit_ok();
`ifdef DRAM_RBUF_LASTCHK_EN
      if (do_push) begin
        if (lq.size() == 0) m_err = 1'b1;
        else if (RLAST_S) begin
          if (m_bc + 1 != lq[0]) m_err = 1'b1;
          void'(lq.pop_front());
          m_bc = 0;
        end else begin
          if (m_bc + 1 == lq[0]) m_err = 1'b1;
          m_bc = m_bc + 1;
        end
      end
      if (do_ar) lq.push_back(int'(ARLEN_M) + 1);
`endif
      if (do_pop) begin
        void'(mq.pop_front());
        m_credits = m_credits + 1;
      end
      if (do_push) begin
        b = '{id: RID_S, data: RDATA_S, resp: RRESP_S, last: RLAST_S};
        mq.push_back(b);
      end
      if (do_ar) m_credits = m_credits - (int'(ARLEN_M) + 1);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (en) begin
      beat_t e;
      bit ok;
      e  = (mq.size() != 0) ? mq[0] : '0;
      ok = model_credit_ok();
      chk("COUNT", 64'(COUNT), 64'(mq.size()));
      chk("RVALID_M", 64'(RVALID_M), 64'(mq.size() != 0));
      chk("RREADY_S", 64'(RREADY_S), 64'(mq.size() != 16));
      chk("R_M beat", 64'({RID_M, RDATA_M, RRESP_M, RLAST_M}), 64'(e));
      chk("ARVALID_S", 64'(ARVALID_S), 64'(ARVALID_M & ok));
      chk("ARREADY_M", 64'(ARREADY_M), 64'(ARREADY_S & ok));
      chk("AR passthru", 64'({ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S}),
          64'({ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}));
      chk("ARADDR_S", 64'(ARADDR_S), 64'(ARADDR_M));
      chk("LAST_ERR", 64'(LAST_ERR), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] d, input logic last);
    RVALID_S = 1'b1; RDATA_S = d; RID_S = 8'h21; RRESP_S = 2'b00; RLAST_S = last;
  endtask

  initial begin
    rst = 1'b0;
    ARID_M = 8'h21; ARADDR_M = 32'h0000_1000; ARLEN_M = 4'd3; ARSIZE_M = 3'd2;
    ARBURST_M = 2'b01; ARVALID_M = 1'b0; ARREADY_S = 1'b1;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0; RREADY_M = 1'b0;
    tick();
    en = 1'b1;

    // reset state; AR credit path visible while still in reset
    ARVALID_M = 1'b1;
    @(negedge clk);
    chk("rst RVALID_M", 64'(RVALID_M), 64'd0);
    chk("rst RREADY_S", 64'(RREADY_S), 64'd1);
    chk("rst COUNT", 64'(COUNT), 64'd0);
    chk("rst LAST_ERR", 64'(LAST_ERR), 64'd0);
    chk("rst ARREADY_M", 64'(ARREADY_M), 64'd1);
    tick();

    // 4-beat burst, master always ready: each beat appears one cycle after its push
    rst = 1'b1;
    tick();                    // AR ARLEN=3 accepted
    ARVALID_M = 1'b0;
    RREADY_M  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(32'hD0 + 32'(i), i == 3);
      tick();
      @(negedge clk);
      chk("burst RDATA_M", 64'(RDATA_M), 64'(32'hD0 + 32'(i)));
      chk("burst RLAST_M", 64'(RLAST_M), 64'(i == 3));
    end
    RVALID_S = 1'b0;
    tick(); tick();
    // all 16 credits back: a max burst is offered
    ARREADY_S = 1'b0; ARVALID_M = 1'b1; ARLEN_M = 4'd15; ARADDR_M = 32'h0000_2000;
    @(negedge clk);
    chk("credits16 ARVALID_S", 64'(ARVALID_S), 64'd1);
    ARREADY_S = 1'b1;
    tick();                    // AR ARLEN=15 accepted, credits exhausted
    ARVALID_M = 1'b0;

    // fill completely with master stalled
    RREADY_M = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_beat(32'h300 + 32'(i), i == 15);
      tick();
    end
    set_beat(32'h3FF, 1'b1);
    ARVALID_M = 1'b1; ARLEN_M = 4'd0; ARADDR_M = 32'h0000_3000;
    @(negedge clk);
    chk("full COUNT", 64'(COUNT), 64'd16);
    chk("full RREADY_S", 64'(RREADY_S), 64'd0);
    chk("nocredit ARVALID_S", 64'(ARVALID_S), 64'd0);
    chk("nocredit ARREADY_M", 64'(ARREADY_M), 64'd0);
    tick();
    RVALID_S = 1'b0; RREADY_M = 1'b1;
    tick();                    // one pop frees one credit
    RREADY_M = 1'b0;
    @(negedge clk);
    chk("credit1 ARVALID_S", 64'(ARVALID_S), 64'd1);
    chk("credit1 COUNT", 64'(COUNT), 64'd15);
    tick();                    // ARLEN=0 accepted
    ARVALID_M = 1'b0;

    // drain to 8 then stream push+pop for 10 cycles
    RREADY_M = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    for (int i = 0; i < 10; i++) begin
      set_beat(32'h400 + 32'(i), i == 0);
      tick();
      @(negedge clk);
      chk("stream COUNT", 64'(COUNT), 64'd8);
      chk("stream RDATA_M", 64'(RDATA_M),
          64'((i < 7) ? 32'h309 + 32'(i) : 32'h400 + 32'(i - 7)));
    end
    RVALID_S = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    @(negedge clk);
    chk("drained RVALID_M", 64'(RVALID_M), 64'd0);

    // reset in the middle of a burst
    ARVALID_M = 1'b1; ARLEN_M = 4'd7; ARADDR_M = 32'h0000_5000;
    tick();
    ARVALID_M = 1'b0; RREADY_M = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(32'h500 + 32'(i), 1'b0);
      tick();
    end
    RVALID_S = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst RVALID_M", 64'(RVALID_M), 64'd0);
    chk("midrst COUNT", 64'(COUNT), 64'd0);
    chk("midrst RDATA_M", 64'(RDATA_M), 64'd0);
    chk("midrst RID_M", 64'(RID_M), 64'd0);
    ARREADY_S = 1'b0; ARVALID_M = 1'b1; ARLEN_M = 4'd15;
    @(negedge clk);
    chk("midrst credits16", 64'(ARVALID_S), 64'd1);
    ARVALID_M = 1'b0; ARREADY_S = 1'b1;
    tick();

    // early RLAST on beat 2 of a 4-beat burst
    ARVALID_M = 1'b1; ARLEN_M = 4'd3; ARADDR_M = 32'h0000_6000;
    tick();
    ARVALID_M = 1'b0; RREADY_M = 1'b1;
    set_beat(32'h600, 1'b0);
    tick();
    set_beat(32'h601, 1'b1);
    tick();
    RVALID_S = 1'b0;
    @(negedge clk);
    chk("early RLAST LAST_ERR", 64'(LAST_ERR), 64'(EXP_ERR));
    tick(); tick(); tick();
    @(negedge clk);
    chk("sticky LAST_ERR", 64'(LAST_ERR), 64'(EXP_ERR));

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
